// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: state encoding,
// default widths and the packed bundle widths of each inter-stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_CNT_W  = 16;

  // Bundle widths callers use when instantiating a stage between two units
  localparam int IFID_W  = 64;
  localparam int IDEX_W  = 147;
  localparam int EXMEM_W = 107;
  localparam int MEMWB_W = 71;

endpackage

// File: rtl/pipe_stage_sat_counter.sv
// Saturating up-counter: counts enabled cycles, sticks at all-ones, cleared only by RST.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage.sv
// Elastic valid/ready pipeline register with optional skid entry, synchronous
// flush and a saturating stall counter for performance debug.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = PIPE_DATA_W,
  parameter int               SKID      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = PIPE_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  pipe_state_e      state_p0;
  logic [WIDTH-1:0] main_p0;
  logic [WIDTH-1:0] skid_p0;
  logic             in_xfer;
  logic             out_xfer;

  assign out_valid = (state_p0 != ST_EMPTY);
  assign out_data  = main_p0;
  assign occupancy = 2'(state_p0);

  // With a skid entry, in_ready depends only on held state, cutting the
  // combinational ready path; without it, ready ripples from downstream.
  assign in_ready = !RST && ((SKID != 0) ? (state_p0 != ST_TWO)
                                         : (!out_valid || out_ready));

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // ---- stage p0: main register and control state ----
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      state_p0 <= ST_EMPTY;
      main_p0  <= RESET_VAL;
    end else begin
      case (state_p0)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_p0  <= in_data;
            state_p0 <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_p0 <= in_data;
          end else if (out_xfer) begin
            state_p0 <= ST_EMPTY;
          end else if (in_xfer && (SKID != 0)) begin
            state_p0 <= ST_TWO;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            main_p0  <= skid_p0;
            state_p0 <= ST_ONE;
          end
        end
        default: state_p0 <= ST_EMPTY;
      endcase
    end
  end

  // Skid data is qualified by state alone, so it needs no reset.
  generate
    if (SKID != 0) begin : g_skid
      always_ff @(posedge CLK) begin
        if ((state_p0 == ST_ONE) && in_xfer && !out_xfer) begin
          skid_p0 <= in_data;
        end
      end
    end else begin : g_noskid
      assign skid_p0 = '0;
    end
  endgenerate

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .inc  (out_valid && !out_ready),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboard bench: three pipe_stage configurations share one randomized
// stimulus stream and are each checked against a queue-based reference model.
module tb_pipe_stage;

  localparam int N = 3;
  localparam int SKIDS [N] = '{1, 1, 0};
  localparam int CMAX  [N] = '{65535, 3, 65535};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b1;

  logic        ir  [N];
  logic        ov  [N];
  logic [7:0]  od  [N];
  logic [1:0]  occ [N];
  logic [15:0] sc  [N];
  logic [1:0]  sc1;

  assign sc[1] = {14'd0, sc1};

  int checks = 0;
  int errors = 0;

  logic [7:0] sbq [N][$];
  logic       rvflag [N] = '{1'b1, 1'b1, 1'b1};
  int         scnt   [N] = '{0, 0, 0};

  always #5 clk = ~clk;

  pipe_stage #(.WIDTH(8), .SKID(1), .RESET_VAL(8'h00), .CNT_W(16)) u_s1 (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .flush(flush), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .occupancy(occ[0]), .stall_cnt(sc[0]));

  pipe_stage #(.WIDTH(8), .SKID(1), .RESET_VAL(8'h00), .CNT_W(2)) u_s1c2 (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .flush(flush), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .occupancy(occ[1]), .stall_cnt(sc1));

  pipe_stage #(.WIDTH(8), .SKID(0), .RESET_VAL(8'h00), .CNT_W(16)) u_s0 (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .flush(flush), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .occupancy(occ[2]), .stall_cnt(sc[2]));

  function automatic void chk(input string nm, input int i,
                              input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h expected %0h at %0t", nm, i, act, exp, $time);
    end
  endfunction

  // Monitor: compares outputs against the model and retires delivered payloads.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      automatic int  sz  = sbq[i].size();
      automatic logic eir = !rst && ((SKIDS[i] != 0) ? (sz < 2) : (sz == 0 || out_ready));
      automatic int  ecnt = (scnt[i] > CMAX[i]) ? CMAX[i] : scnt[i];
      chk("in_ready", i, {15'd0, ir[i]}, {15'd0, eir});
      chk("out_valid", i, {15'd0, ov[i]}, {15'd0, (sz > 0)});
      chk("occupancy", i, {14'd0, occ[i]}, 16'(sz));
      chk("stall_cnt", i, sc[i], 16'(ecnt));
      if (sz > 0) chk("out_data", i, {8'd0, od[i]}, {8'd0, sbq[i][0]});
      else if (rvflag[i]) chk("out_data_rst", i, {8'd0, od[i]}, 16'd0);
      if (rst) begin
        scnt[i] = 0;
      end else begin
        if (sz > 0 && !out_ready) scnt[i]++;
        if (ov[i] && out_ready && sz > 0) void'(sbq[i].pop_front());
      end
    end
  end

  // Stimulus bookkeeping: every accepted payload becomes an expected output.
  always @(negedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (rst || flush) begin
        sbq[i].delete();
        rvflag[i] = 1'b1;
      end else if (in_valid && ir[i]) begin
        sbq[i].push_back(in_data);
        rvflag[i] = 1'b0;
      end
    end
  end

  task automatic cyc(input logic r, input logic iv, input logic [7:0] d,
                     input logic f, input logic ordy);
    @(posedge clk);
    #1;
    rst = r; in_valid = iv; in_data = d; flush = f; out_ready = ordy;
  endtask

  initial begin
    cyc(1, 0, 8'h00, 0, 1);
    cyc(1, 0, 8'h00, 0, 1);
    cyc(0, 0, 8'h00, 0, 1);
    // Streaming at full rate
    cyc(0, 1, 8'h11, 0, 1);
    cyc(0, 1, 8'h22, 0, 1);
    cyc(0, 1, 8'h33, 0, 1);
    cyc(0, 0, 8'h00, 0, 1);
    cyc(0, 0, 8'h00, 0, 1);
    // Fill skid, then drain
    cyc(0, 1, 8'h0A, 0, 0);
    cyc(0, 1, 8'h0B, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 0, 1);
    cyc(0, 0, 8'h00, 0, 1);
    cyc(0, 0, 8'h00, 0, 1);
    // Flush a full stage while a new payload is offered
    cyc(0, 1, 8'h0A, 0, 0);
    cyc(0, 1, 8'h0B, 0, 0);
    cyc(0, 1, 8'h0C, 1, 0);
    cyc(0, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 0, 1);
    // Long stall to saturate the narrow counter, then reset
    cyc(0, 1, 8'h5A, 0, 0);
    for (int k = 0; k < 6; k++) cyc(0, 0, 8'h00, 0, 0);
    cyc(1, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 0, 1);
    // Downstream ready toggling with continuous upstream
    for (int k = 0; k < 10; k++) cyc(0, 1, 8'(8'h60 + k), 0, (k % 2) == 1);
    cyc(0, 0, 8'h00, 0, 1);
    cyc(0, 0, 8'h00, 0, 1);
    // Randomized traffic with occasional flush and reset
    for (int k = 0; k < 2000; k++) begin
      cyc(($urandom_range(199) == 0), ($urandom_range(3) != 0), 8'($urandom),
          ($urandom_range(19) == 0), ($urandom_range(2) != 0));
    end
    for (int k = 0; k < 4; k++) cyc(0, 0, 8'h00, 0, 1);
    @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
